// File: rtl/dual_phase_addr_gen.sv
// Phase-accumulator address generator feeding both ports of a dual-port sine ROM.
// addr2 runs at addr1 + offset; offset updates are held back until the accumulator wraps.
module dual_phase_addr_gen #(
  parameter int          AW         = 8,
  parameter logic [AW-1:0] RST_OFFSET = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] incr,
  input  logic          sync_clr,
  input  logic          offset_ld,
  input  logic [AW-1:0] offset_in,
  output logic [AW-1:0] addr1,
  output logic [AW-1:0] addr2,
  output logic          wrap,
  output logic          offset_pend
);

  logic [AW-1:0] r_acc;
  logic [AW-1:0] r_offset_act;
  logic [AW-1:0] r_offset_pnd;
  logic          r_pend;
  logic [AW-1:0] r_addr2;
  logic          r_wrap;

  logic [AW:0]   w_sum;
  logic          w_carry;
  logic [AW-1:0] w_acc_nxt;
  logic [AW-1:0] w_act_nxt;
  logic [AW-1:0] w_pnd_nxt;
  logic          w_pend_nxt;
  logic          w_wrap_nxt;

  assign w_sum   = {1'b0, r_acc} + {1'b0, incr};
  assign w_carry = w_sum[AW];

  always_comb begin
    w_acc_nxt  = r_acc;
    w_act_nxt  = r_offset_act;
    w_pnd_nxt  = r_offset_pnd;
    w_pend_nxt = r_pend;
    w_wrap_nxt = 1'b0;
    if (sync_clr) begin
      w_acc_nxt  = '0;
      w_pend_nxt = 1'b0;
      if (offset_ld)   w_act_nxt = offset_in;
      else if (r_pend) w_act_nxt = r_offset_pnd;
    end else if (en && w_carry) begin
      // Wrap point: the only place a deferred offset may take effect.
      w_acc_nxt  = w_sum[AW-1:0];
      w_wrap_nxt = 1'b1;
      w_pend_nxt = 1'b0;
      if (offset_ld)   w_act_nxt = offset_in;
      else if (r_pend) w_act_nxt = r_offset_pnd;
    end else begin
      if (en) w_acc_nxt = w_sum[AW-1:0];
      if (offset_ld) begin
        w_pnd_nxt  = offset_in;
        w_pend_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_offset_act <= RST_OFFSET;
      r_offset_pnd <= '0;
      r_pend       <= 1'b0;
      r_addr2      <= RST_OFFSET;
      r_wrap       <= 1'b0;
    end else begin
      r_acc        <= w_acc_nxt;
      r_offset_act <= w_act_nxt;
      r_offset_pnd <= w_pnd_nxt;
      r_pend       <= w_pend_nxt;
      r_addr2      <= w_acc_nxt + w_act_nxt;
      r_wrap       <= w_wrap_nxt;
    end
  end

  assign addr1       = r_acc;
  assign addr2       = r_addr2;
  assign wrap        = r_wrap;
  assign offset_pend = r_pend;

endmodule

// File: tb/tb_dual_phase_addr_gen.sv
// Self-checking bench for dual_phase_addr_gen: vector table, directed corner cases,
// and randomized traffic against an arithmetic reference model.
module tb_dual_phase_addr_gen;
  localparam int AW  = 8;
  localparam int MOD = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [AW-1:0] incr = '0;
  logic          sync_clr = 1'b0;
  logic          offset_ld = 1'b0;
  logic [AW-1:0] offset_in = '0;
  logic [AW-1:0] addr1, addr2;
  logic          wrap, offset_pend;

  dual_phase_addr_gen #(.AW(AW), .RST_OFFSET(8'd0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .incr(incr), .sync_clr(sync_clr),
    .offset_ld(offset_ld), .offset_in(offset_in), .addr1(addr1), .addr2(addr2),
    .wrap(wrap), .offset_pend(offset_pend)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  int m_acc, m_act, m_pnd, m_pend, m_wrap;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_acc = 0; m_act = 0; m_pnd = 0; m_pend = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input int e, input int inc, input int clr, input int ld, input int oin);
    int s;
    s = m_acc + inc;
    if (clr != 0) begin
      if (ld != 0) m_act = oin;
      else if (m_pend != 0) m_act = m_pnd;
      m_pend = 0; m_acc = 0; m_wrap = 0;
    end else if (e != 0 && s >= MOD) begin
      m_acc = s - MOD; m_wrap = 1;
      if (ld != 0) m_act = oin;
      else if (m_pend != 0) m_act = m_pnd;
      m_pend = 0;
    end else begin
      if (e != 0) m_acc = s;
      m_wrap = 0;
      if (ld != 0) begin m_pnd = oin; m_pend = 1; end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".addr1"}, int'(addr1), m_acc);
    chk({tag, ".addr2"}, int'(addr2), (m_acc + m_act) % MOD);
    chk({tag, ".wrap"}, int'(wrap), m_wrap);
    chk({tag, ".pend"}, int'(offset_pend), m_pend);
  endtask

  // drive one cycle, clock it, and advance the model; returns 1 ns after the edge
  task automatic step(input int e, input int inc, input int clr, input int ld, input int oin);
    en = e[0]; incr = inc[AW-1:0]; sync_clr = clr[0]; offset_ld = ld[0]; offset_in = oin[AW-1:0];
    @(posedge clk);
    model_edge(e, inc, clr, ld, oin);
    #1;
    en = 1'b0; offset_ld = 1'b0; sync_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int en, incr, clr, ld, oin;
    int a1, a2, wr, pd;
  } vec_t;

  vec_t tbl[13];
  int   sum3;

  initial begin
    tbl[0]  = '{1, 100, 0, 0, 0,    100, 100, 0, 0};
    tbl[1]  = '{1, 100, 0, 1, 64,   200, 200, 0, 1};
    tbl[2]  = '{0, 0,   0, 0, 0,    200, 200, 0, 1};
    tbl[3]  = '{1, 0,   0, 0, 0,    200, 200, 0, 1};
    tbl[4]  = '{1, 100, 0, 0, 0,    44,  108, 1, 0};
    tbl[5]  = '{1, 212, 0, 0, 0,    0,   64,  1, 0};
    tbl[6]  = '{1, 255, 0, 0, 0,    255, 63,  0, 0};
    tbl[7]  = '{1, 1,   0, 1, 32,   0,   32,  1, 0};
    tbl[8]  = '{0, 0,   0, 1, 200,  0,   32,  0, 1};
    tbl[9]  = '{1, 5,   1, 0, 0,    0,   200, 0, 0};
    tbl[10] = '{1, 128, 0, 0, 0,    128, 72,  0, 0};
    tbl[11] = '{1, 128, 0, 0, 0,    0,   200, 1, 0};
    tbl[12] = '{1, 128, 0, 0, 0,    128, 72,  0, 0};

    do_reset();
    chk("reset.addr1", int'(addr1), 0);
    chk("reset.addr2", int'(addr2), 0);
    chk("reset.wrap", int'(wrap), 0);
    chk("reset.pend", int'(offset_pend), 0);

    // vector table
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].en, tbl[i].incr, tbl[i].clr, tbl[i].ld, tbl[i].oin);
      chk($sformatf("vec%0d.addr1", i), int'(addr1), tbl[i].a1);
      chk($sformatf("vec%0d.addr2", i), int'(addr2), tbl[i].a2);
      chk($sformatf("vec%0d.wrap", i), int'(wrap), tbl[i].wr);
      chk($sformatf("vec%0d.pend", i), int'(offset_pend), tbl[i].pd);
    end

    // incr=1 full period: wrap only on the 255->0 step, addr2 tracks addr1
    do_reset();
    for (int i = 1; i <= 257; i++) begin
      step(1, 1, 0, 0, 0);
      chk("cnt1.addr1", int'(addr1), i % MOD);
      chk("cnt1.wrap", int'(wrap), (i % MOD == 0) ? 1 : 0);
      chk("cnt1.addr2", int'(addr2), i % MOD);
    end

    // incr=3 from 0: wrap lands on addr1=2
    do_reset();
    sum3 = 0;
    for (int i = 0; i < 86; i++) begin
      step(1, 3, 0, 0, 0);
      sum3 += 3;
      if (i < 85) chk("cnt3.nowrap", int'(wrap), 0);
    end
    chk("cnt3.addr1", int'(addr1), sum3 - MOD);
    chk("cnt3.wrap", int'(wrap), 1);

    // deferred offset: load at acc=10, applied at wrap
    do_reset();
    step(1, 10, 0, 0, 0);
    step(0, 0, 0, 1, 64);
    chk("defer.pend", int'(offset_pend), 1);
    chk("defer.addr2", int'(addr2), 10);
    step(1, 246, 0, 0, 0);
    chk("defer.wrap_a1", int'(addr1), 0);
    chk("defer.wrap_a2", int'(addr2), 64);
    chk("defer.wrap_pend", int'(offset_pend), 0);

    // back-to-back loads: last one wins
    do_reset();
    step(1, 100, 0, 1, 64);
    step(1, 100, 0, 1, 128);
    step(1, 56, 0, 0, 0);
    chk("b2b.addr1", int'(addr1), 0);
    chk("b2b.addr2", int'(addr2), 128);
    chk("b2b.wrap", int'(wrap), 1);
    // load in the wrap cycle supersedes a pending value
    step(1, 200, 0, 1, 64);
    step(1, 56, 0, 1, 32);
    chk("ldwrap.addr2", int'(addr2), 32);
    chk("ldwrap.pend", int'(offset_pend), 0);
    chk("ldwrap.wrap", int'(wrap), 1);

    // sync_clr with pending offset
    do_reset();
    step(1, 200, 0, 0, 0);
    step(0, 0, 0, 1, 96);
    step(1, 7, 1, 0, 0);
    chk("clr.addr1", int'(addr1), 0);
    chk("clr.addr2", int'(addr2), 96);
    chk("clr.wrap", int'(wrap), 0);
    chk("clr.pend", int'(offset_pend), 0);

    // async reset between edges at addr1=77
    do_reset();
    step(1, 50, 0, 1, 16);
    step(1, 27, 0, 0, 0);
    chk("arst.pre", int'(addr1), 77);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.addr1", int'(addr1), 0);
    chk("arst.addr2", int'(addr2), 0);
    chk("arst.wrap", int'(wrap), 0);
    chk("arst.pend", int'(offset_pend), 0);
    #1 rst_n = 1'b1;
    model_reset();
    step(1, 1, 0, 0, 0);
    chk("arst.resume", int'(addr1), 1);
    check_model("arst.model");

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int e, inc, clr, ld, oin, sel;
      e   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      sel = $urandom_range(0, 9);
      inc = (sel == 0) ? 0 : (sel < 4) ? $urandom_range(128, 255) : $urandom_range(1, 40);
      clr = ($urandom_range(0, 39) == 0) ? 1 : 0;
      ld  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      oin = $urandom_range(0, 255);
      step(e, inc, clr, ld, oin);
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dual_phase_addr_gen.md
Name: dual_phase_addr_gen

Overview:
Phase-accumulator address generator that sits directly upstream of the dual-port sine ROM and drives its two address inputs. addr1 advances by a programmable step each enabled cycle. addr2 tracks addr1 plus a programmable phase offset. Offset changes are deferred to the accumulator wrap point, so the second output never takes a phase jump mid-period.

Parameters:
AW, 8, address/accumulator width; matches ROM address width
RST_OFFSET, 0, value of the active offset after reset

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  advance accumulator this cycle
incr  input  AW  step added per enabled cycle (frequency control)
sync_clr  input  1  synchronous phase clear
offset_ld  input  1  single-cycle strobe: capture offset_in as pending offset
offset_in  input  AW  requested phase offset (addr2 − addr1, mod 2^AW)
addr1  output  AW  ROM address, reference phase (registered)
addr2  output  AW  ROM address, shifted phase (registered)
wrap  output  1  one-cycle pulse marking accumulator wrap
offset_pend  output  1  pending offset not yet applied

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - acc=0, addr1=0.
  - offset_act=RST_OFFSET, addr2=RST_OFFSET.
  - offset_pend=0, wrap=0.
  - Takes effect immediately regardless of clk. First update follows the first rising edge after rst_n deasserts.
- Internal state:
  - acc: AW bits.
  - offset_act, offset_pnd: AW bits each.
  - pend: 1 bit, driven out as offset_pend.
- Sum: {carry, nxt} = acc + incr, computed at AW+1 bits. Arithmetic is modulo 2^AW.
- Per-cycle priority, highest first:
  1. sync_clr=1:
     - acc<=0.
     - If offset_ld=1: offset_act<=offset_in.
     - Else if pend=1: offset_act<=offset_pnd.
     - pend<=0, wrap<=0.
     - en and incr are ignored this cycle.
  2. en=1, carry=1 (wrap):
     - acc<=nxt, wrap<=1.
     - If offset_ld=1: offset_act<=offset_in, pend<=0. A new load at the wrap bypasses and supersedes any older pending value.
     - Else if pend=1: offset_act<=offset_pnd, pend<=0.
  3. en=1, carry=0: acc<=nxt, wrap<=0.
  4. en=0: acc holds, wrap<=0.
- Offset load outside cases 1/2: offset_pnd<=offset_in, pend<=1. A second load before the wrap overwrites offset_pnd; only the last value is applied.
- Outputs:
  - addr1 equals acc.
  - addr2 is a register loaded with (next acc + next offset_act) mod 2^AW. addr1 and addr2 change on the same edge, with no cycle of skew.
  - Latency: the edge that samples en=1 updates addr1 and addr2 together. The ROM reads combinationally, so the samples are valid in the same cycle.
- wrap:
  - High for exactly the cycle in which addr1 holds the post-wrap value.
  - Never high two consecutive cycles unless each cycle wraps independently (e.g. incr ≥ 2^(AW-1) with matching acc values).
- incr=0 with en=1: acc holds, no wrap, pending offset stays pending.
- incr may change any cycle; the new value is used on the next enabled edge.
- offset_in is sampled only when offset_ld=1.

Test Plan:
1. Reset, then en=1, incr=1, RST_OFFSET=0, AW=8 → addr1 0,1,2,…,255,0. wrap high only in the cycle addr1=0 after 255. addr2==addr1 throughout.
2. Hold en=1, incr=3 from acc=0 → addr1 sequence 0,3,…,255,2. wrap asserts in the cycle addr1=2 (carry from 255+3).
3. acc=10, offset_ld with offset_in=64 → offset_pend=1 next cycle and addr2 stays addr1+0. At the next wrap addr2 becomes addr1+64 (e.g. addr1=0 → addr2=64) and offset_pend clears.
4. Back-to-back loads 64 then 128 before the wrap → at the wrap addr2=addr1+128. Separately, a load of 32 in the exact wrap cycle with 64 pending → at that wrap addr2=addr1+32, offset_pend=0.
5. acc=200, offset_pnd=96 pending, sync_clr=1 with en=1 → next cycle addr1=0, addr2=96, wrap=0, offset_pend=0.
6. Mid-run at addr1=77, pulse rst_n low between clock edges → addr1=0, addr2=RST_OFFSET, wrap=0, offset_pend=0 before the next edge. Counting resumes from 0 on the first edge after release.
